in_fetch: RTL

IN_FETCH -- requirements
Module: in_fetch

---
 rtl/in_fetch_pkg.sv | 13 +
 rtl/in_fetch_fifo.sv | 62 ++++++
 rtl/in_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/in_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package in_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pair_t;

endpackage

// File: rtl/in_fetch_fifo.sv
// Small in-order FIFO with synchronous flush, used for the PC queue and the response buffer.
module in_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);
   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

endmodule

// File: rtl/in_fetch.sv
// Instruction fetch stage: credit-limited memory requests, in-order response buffering,
// IF/ID output register, and redirect handling that drops stale responses.
module in_fetch
   import in_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] PC_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [CW-1:0]   r_in_flight;
   logic [CW-1:0]   r_drop_cnt;
   logic [XLEN-1:0] r_pc_out;
   logic [XLEN-1:0] r_instr_out;
   logic            r_valid_out;

   logic            w_credit;
   logic            w_accept;
   logic            w_resp_ok;
   logic            w_drop;
   logic            w_keep;
   logic            w_load;
   logic            w_use_buf;
   logic            w_use_byp;
   logic            w_buf_push;
   logic            w_buf_pop;
   logic            w_pcq_push;
   logic [CW-1:0]   w_in_flight_nxt;
   logic [XLEN-1:0] w_pcq_head;
   logic [CW-1:0]   w_pcq_count;
   fetch_pair_t     w_buf_head;
   logic [CW-1:0]   w_buf_count;

   // Every outstanding request already owns a buffer slot, so responses can never overflow.
   assign w_credit       = ({1'b0, r_in_flight} + {1'b0, w_buf_count}) < DEPTH_C;
   assign imem_req_valid = reset && w_credit;
   assign imem_addr      = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding (e.g. stragglers from before reset) are ignored.
   assign w_resp_ok  = imem_resp_valid && (r_in_flight != '0);
   assign w_drop     = w_resp_ok && (r_drop_cnt != '0);
   assign w_keep     = w_resp_ok && (r_drop_cnt == '0) && (w_pcq_count != '0);

   assign w_load     = !r_valid_out || !stall;
   assign w_use_buf  = w_load && (w_buf_count != '0);
   assign w_use_byp  = w_load && (w_buf_count == '0) && w_keep;
   assign w_buf_push = w_keep && !w_use_byp && !redirect_valid;
   assign w_buf_pop  = w_use_buf && !redirect_valid;
   assign w_pcq_push = w_accept && !redirect_valid;

   assign w_in_flight_nxt = r_in_flight + CW'(w_accept) - CW'(w_resp_ok);

   in_fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_pc_q (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (w_pcq_push),
      .push_data (r_fetch_pc),
      .pop       (w_keep),
      .head_data (w_pcq_head),
      .count     (w_pcq_count)
   );

   in_fetch_fifo #(
      .WIDTH ($bits(fetch_pair_t)),
      .DEPTH (DEPTH)
   ) u_resp_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (w_buf_push),
      .push_data ({w_pcq_head, imem_resp_data}),
      .pop       (w_buf_pop),
      .head_data (w_buf_head),
      .count     (w_buf_count)
   );

   // Redirect outranks stall; everything still in flight after this edge becomes stale.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc  <= RESET_PC;
         r_in_flight <= '0;
         r_drop_cnt  <= '0;
         r_pc_out    <= '0;
         r_instr_out <= NOP_INSTR;
         r_valid_out <= 1'b0;
      end else begin
         r_in_flight <= w_in_flight_nxt;
         if (redirect_valid) begin
            r_fetch_pc  <= redirect_pc;
            r_drop_cnt  <= w_in_flight_nxt;
            r_instr_out <= NOP_INSTR;
            r_valid_out <= 1'b0;
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_use_buf) begin
               r_pc_out    <= w_buf_head.pc;
               r_instr_out <= w_buf_head.instr;
               r_valid_out <= 1'b1;
            end else if (w_use_byp) begin
               r_pc_out    <= w_pcq_head;
               r_instr_out <= imem_resp_data;
               r_valid_out <= 1'b1;
            end else if (w_load) begin
               r_instr_out <= NOP_INSTR;
               r_valid_out <= 1'b0;
            end
         end
      end
   end

   assign PC_out          = r_pc_out;
   assign instruction_out = r_instr_out;
   assign valid_out       = r_valid_out;

endmodule
